mips_exec_unit: RTL and testbench
=================================

MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 Parameter RESET_TARGET, default 32'h0000_0000, reset value of held target register.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 clk_enable  in  1  advances held-target/delay registers when high.
REQ-005 alu_op  in  2  class: 00 add, 01 subtract, 10 R-type (function_code), 11 I-type (opcode).
REQ-006 opcode  in  6  instruction[31:26].
REQ-007 function_code  in  6  instruction[5:0].
REQ-008 shamt  in  5  instruction[10:6].
REQ-009 A  in  32  rs value, also JR/JALR target.
REQ-010 B  in  32  second operand (rt or extended immediate).
REQ-011 pc_plus4, branch_addr, jump_addr  in  32 each  candidate next-PC values.
REQ-012 condition_met, jump1, jump2, branch  in  1 each  branch taken; J/JAL; JR/JALR; any branch.
REQ-013 alu_out  out  32  result; zero  out  1  high when alu_out==0.
REQ-014 hi, lo  out  32 each  mult/div results (combinational).
REQ-015 tgt_addr_0  out  32  selected target this cycle; pcin  out  32  next PC; delay  out  1  delay-slot flag.

Function
REQ-016 alu_op 00 SHALL give A+B; 01 SHALL give A-B; all arithmetic modulo 2^32, no overflow trap.
REQ-017 alu_op 10 decode: 00 SLL B<<shamt; 02 SRL; 03 SRA (arithmetic); 04/06/07 SLLV/SRLV/SRAV B by A[4:0]; 21 ADDU; 23 SUBU; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT signed; 2B SLTU; 08/09 JR/JALR alu_out=A.
REQ-018 alu_op 11 decode: 09 ADDIU; 0A SLTI; 0B SLTIU; 0C ANDI; 0D ORI; 0E XORI; 0F LUI = {B[15:0],16'h0}.
REQ-019 SLT/SLTU outputs 32'd1 or 32'd0; unknown codes SHALL give alu_out=0.
REQ-020 MULT/MULTU (18/19): {hi,lo}=64-bit signed/unsigned A*B; alu_out=0.
REQ-021 DIV/DIVU (1A/1B): lo=quotient, hi=remainder, signed truncating toward zero (remainder sign of A)/unsigned; divisor 0 SHALL give hi=lo=0.
REQ-022 Non-mult/div operations SHALL drive hi=lo=0.
REQ-023 tgt_addr_0 priority: jump2 -> A; else jump1 -> jump_addr; else condition_met -> branch_addr; else pc_plus4.
REQ-024 On rising clk with clk_enable=1: tgt_q<=tgt_addr_0, delay<=branch|jump1|jump2; clk_enable=0 holds both.
REQ-025 pcin SHALL equal tgt_q when delay=1, else pc_plus4 (one-instruction delay slot); untaken branch yields tgt_q=pc_plus4 of branch.

Reset
REQ-026 reset low SHALL immediately set tgt_q=RESET_TARGET, delay=0, regardless of clk/clk_enable; combinational outputs unaffected.
REQ-027 Deassertion SHALL take effect at next qualifying rising edge; no other state exists.

Configuration
REQ-028 Macro MULTDIV_EN defined: REQ-020/021 implemented; undefined: no multiplier/divider, hi=lo=0 and alu_out=0 for function codes 18-1B.

Verification
REQ-029 alu_op=10, fn=23, A=5, B=7 -> alu_out=FFFF_FFFE, zero=0; fn=2A same operands -> 1; fn=2B A=FFFF_FFFF,B=1 -> 0.
REQ-030 alu_op=10, fn=03, B=8000_0000, shamt=4 -> F800_0000; alu_op=11, opcode=0F, B=0000_1234 -> 1234_0000.
REQ-031 MULTDIV_EN: fn=18, A=FFFF_FFFE, B=3 -> hi=FFFF_FFFF, lo=FFFF_FFFA; fn=1A, A=-7, B=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF; B=0 -> hi=lo=0.
REQ-032 jump2=1,jump1=1,condition_met=1, A=0000_0040 -> tgt_addr_0=0000_0040; then jump1 only -> jump_addr; none -> pc_plus4.
REQ-033 branch=1,condition_met=1,branch_addr=100, clk_enable pulse -> delay=1, pcin=100 next cycle; following enabled edge with branch=0 -> delay=0, pcin=pc_plus4.
REQ-034 reset low mid-operation with delay=1 -> delay=0, pcin=pc_plus4 asynchronously.

Source files
------------

// File: rtl/mips_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mips_exec_unit
//  Function : MIPS execute stage. Contains the ALU, an optional HI/LO
//             multiplier/divider (enabled by defining MULTDIV_EN), next-PC
//             target selection and a one-instruction delay-slot register.
//  Revision : 1.0  initial release
// ============================================================================
module mips_exec_unit #(
    parameter logic [31:0] RESET_TARGET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  opcode,
    input  logic [5:0]  function_code,
    input  logic [4:0]  shamt,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic        condition_met,
    input  logic        jump1,
    input  logic        jump2,
    input  logic        branch,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] tgt_addr_0,
    output logic [31:0] pcin,
    output logic        delay
);

    logic [31:0] tgt_q, tgt_d;
    logic        delay_q, delay_d;

    logic [31:0] w_slt_s, w_slt_u, w_sra, w_srav;
    logic [4:0]  w_vsh;

    assign w_vsh   = A[4:0];
    assign w_slt_s = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
    assign w_slt_u = (A < B) ? 32'd1 : 32'd0;
    assign w_sra   = $unsigned($signed(B) >>> shamt);
    assign w_srav  = $unsigned($signed(B) >>> w_vsh);

`ifdef MULTDIV_EN
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;
    logic        w_div0;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'b0, A} * {32'b0, B};
    assign w_div0   = (B == 32'd0);
    // Operands are muxed away from zero so the divide never sees a zero divisor.
    assign w_quo_s  = w_div0 ? 32'd0 : $unsigned($signed(A) / $signed(w_div0 ? 32'd1 : B));
    assign w_rem_s  = w_div0 ? 32'd0 : $unsigned($signed(A) % $signed(w_div0 ? 32'd1 : B));
    assign w_quo_u  = w_div0 ? 32'd0 : A / (w_div0 ? 32'd1 : B);
    assign w_rem_u  = w_div0 ? 32'd0 : A % (w_div0 ? 32'd1 : B);
`endif

    always_comb begin
        alu_out = 32'd0;
        hi      = 32'd0;
        lo      = 32'd0;
        case (alu_op)
            2'b00: alu_out = A + B;
            2'b01: alu_out = A - B;
            2'b10: begin
                case (function_code)
                    6'h00: alu_out = B << shamt;
                    6'h02: alu_out = B >> shamt;
                    6'h03: alu_out = w_sra;
                    6'h04: alu_out = B << w_vsh;
                    6'h06: alu_out = B >> w_vsh;
                    6'h07: alu_out = w_srav;
                    6'h08,
                    6'h09: alu_out = A;
`ifdef MULTDIV_EN
                    6'h18: begin
                        hi = w_prod_s[63:32];
                        lo = w_prod_s[31:0];
                    end
                    6'h19: begin
                        hi = w_prod_u[63:32];
                        lo = w_prod_u[31:0];
                    end
                    6'h1A: begin
                        hi = w_rem_s;
                        lo = w_quo_s;
                    end
                    6'h1B: begin
                        hi = w_rem_u;
                        lo = w_quo_u;
                    end
`endif
                    6'h21: alu_out = A + B;
                    6'h23: alu_out = A - B;
                    6'h24: alu_out = A & B;
                    6'h25: alu_out = A | B;
                    6'h26: alu_out = A ^ B;
                    6'h27: alu_out = ~(A | B);
                    6'h2A: alu_out = w_slt_s;
                    6'h2B: alu_out = w_slt_u;
                    default: alu_out = 32'd0;
                endcase
            end
            default: begin
                case (opcode)
                    6'h09: alu_out = A + B;
                    6'h0A: alu_out = w_slt_s;
                    6'h0B: alu_out = w_slt_u;
                    6'h0C: alu_out = A & B;
                    6'h0D: alu_out = A | B;
                    6'h0E: alu_out = A ^ B;
                    6'h0F: alu_out = {B[15:0], 16'h0000};
                    default: alu_out = 32'd0;
                endcase
            end
        endcase
    end

    assign zero = (alu_out == 32'd0);

    always_comb begin
        if (jump2)
            tgt_addr_0 = A;
        else if (jump1)
            tgt_addr_0 = jump_addr;
        else if (condition_met)
            tgt_addr_0 = branch_addr;
        else
            tgt_addr_0 = pc_plus4;
    end

    assign tgt_d   = clk_enable ? tgt_addr_0 : tgt_q;
    assign delay_d = clk_enable ? (branch | jump1 | jump2) : delay_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q   <= RESET_TARGET;
            delay_q <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            delay_q <= delay_d;
        end
    end

    // The instruction after a branch/jump (delay slot) still uses pc_plus4;
    // the captured target takes over one instruction later.
    assign pcin  = delay_q ? tgt_q : pc_plus4;
    assign delay = delay_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_exec_unit
//  Function : Scoreboard bench for mips_exec_unit with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  function_code = 6'h00;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] pc_plus4 = 32'd0;
    logic [31:0] branch_addr = 32'd0;
    logic [31:0] jump_addr = 32'd0;
    logic        condition_met = 1'b0;
    logic        jump1 = 1'b0;
    logic        jump2 = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] alu_out, hi, lo, tgt_addr_0, pcin;
    logic        zero, delay;

    mips_exec_unit #(.RESET_TARGET(32'hBFC0_0000)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .alu_op(alu_op), .opcode(opcode), .function_code(function_code),
        .shamt(shamt), .A(A), .B(B), .pc_plus4(pc_plus4),
        .branch_addr(branch_addr), .jump_addr(jump_addr),
        .condition_met(condition_met), .jump1(jump1), .jump2(jump2),
        .branch(branch), .alu_out(alu_out), .zero(zero), .hi(hi), .lo(lo),
        .tgt_addr_0(tgt_addr_0), .pcin(pcin), .delay(delay)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] tgt;
        logic [31:0] pcin;
        logic        d;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation is pushed per stimulus cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "alu_out", alu_out, e.alu);
            chk(e.name, "zero", {31'd0, zero}, {31'd0, e.z});
            chk(e.name, "hi", hi, e.hi);
            chk(e.name, "lo", lo, e.lo);
            chk(e.name, "tgt_addr_0", tgt_addr_0, e.tgt);
            chk(e.name, "pcin", pcin, e.pcin);
            chk(e.name, "delay", {31'd0, delay}, {31'd0, e.d});
        end
    end

    // ALU-only vector: controls idle, delay known to be 0.
    task automatic alu_vec(input string nm, input logic [1:0] op, input logic [5:0] fn,
                           input logic [5:0] opc, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_alu, input logic [31:0] e_hi, input logic [31:0] e_lo);
        exp_t e;
        @(posedge clk); #1;
        alu_op = op; function_code = fn; opcode = opc; shamt = sh; A = a; B = b;
        clk_enable = 1'b0; branch = 1'b0; condition_met = 1'b0; jump1 = 1'b0; jump2 = 1'b0;
        pc_plus4 = 32'h0000_1000;
        e = '{nm, e_alu, (e_alu == 32'd0), e_hi, e_lo, 32'h0000_1000, 32'h0000_1000, 1'b0};
        q.push_back(e);
    endtask

    // Control vector: alu_op=add with B=0 so alu_out follows A.
    task automatic ctl_vec(input string nm, input logic rst_n, input logic ce,
                           input logic br, input logic cm, input logic j1, input logic j2,
                           input logic [31:0] a, input logic [31:0] pc4,
                           input logic [31:0] ba, input logic [31:0] ja,
                           input logic [31:0] e_tgt, input logic [31:0] e_pcin, input logic e_d);
        exp_t e;
        @(posedge clk); #1;
        alu_op = 2'b00; function_code = 6'h00; opcode = 6'h00; shamt = 5'd0; B = 32'd0;
        reset = rst_n; clk_enable = ce; branch = br; condition_met = cm; jump1 = j1; jump2 = j2;
        A = a; pc_plus4 = pc4; branch_addr = ba; jump_addr = ja;
        e = '{nm, a, (a == 32'd0), 32'd0, 32'd0, e_tgt, e_pcin, e_d};
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        ctl_vec("reset_state", 1, 0, 0, 0, 0, 0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h1000, 32'h1000, 0);

        alu_vec("add_wrap", 2'b00, 6'h00, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0);
        alu_vec("sub",      2'b01, 6'h00, 6'h00, 5'd0, 32'h3, 32'h5, 32'hFFFF_FFFE, 32'h0, 32'h0);
        alu_vec("subu",     2'b10, 6'h23, 6'h00, 5'd0, 32'h5, 32'h7, 32'hFFFF_FFFE, 32'h0, 32'h0);
        alu_vec("slt",      2'b10, 6'h2A, 6'h00, 5'd0, 32'h5, 32'h7, 32'h1, 32'h0, 32'h0);
        alu_vec("slt_neg",  2'b10, 6'h2A, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'h0);
        alu_vec("sltu",     2'b10, 6'h2B, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0);
        alu_vec("sra",      2'b10, 6'h03, 6'h00, 5'd4, 32'h0, 32'h8000_0000, 32'hF800_0000, 32'h0, 32'h0);
        alu_vec("srl",      2'b10, 6'h02, 6'h00, 5'd4, 32'h0, 32'h8000_0000, 32'h0800_0000, 32'h0, 32'h0);
        alu_vec("sll31",    2'b10, 6'h00, 6'h00, 5'd31, 32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h0);
        alu_vec("sllv",     2'b10, 6'h04, 6'h00, 5'd0, 32'h21, 32'h3, 32'h6, 32'h0, 32'h0);
        alu_vec("srlv",     2'b10, 6'h06, 6'h00, 5'd0, 32'h8, 32'h8000_0000, 32'h0080_0000, 32'h0, 32'h0);
        alu_vec("srav",     2'b10, 6'h07, 6'h00, 5'd0, 32'h24, 32'hF000_0000, 32'hFF00_0000, 32'h0, 32'h0);
        alu_vec("and",      2'b10, 6'h24, 6'h00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 32'h0);
        alu_vec("or",       2'b10, 6'h25, 6'h00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0, 32'h0);
        alu_vec("xor",      2'b10, 6'h26, 6'h00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0);
        alu_vec("nor",      2'b10, 6'h27, 6'h00, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 32'h0, 32'h0);
        alu_vec("jr",       2'b10, 6'h08, 6'h00, 5'd0, 32'h1234_5678, 32'h9, 32'h1234_5678, 32'h0, 32'h0);
        alu_vec("fn_unk",   2'b10, 6'h3F, 6'h00, 5'd0, 32'h1234_5678, 32'h9, 32'h0, 32'h0, 32'h0);
        alu_vec("lui",      2'b11, 6'h00, 6'h0F, 5'd0, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 32'h0, 32'h0);
        alu_vec("slti",     2'b11, 6'h00, 6'h0A, 5'd0, 32'hFFFF_FFFE, 32'h1, 32'h1, 32'h0, 32'h0);
        alu_vec("sltiu",    2'b11, 6'h00, 6'h0B, 5'd0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0, 32'h0);
        alu_vec("andi",     2'b11, 6'h00, 6'h0C, 5'd0, 32'h1234, 32'hFF, 32'h34, 32'h0, 32'h0);
        alu_vec("addiu",    2'b11, 6'h00, 6'h09, 5'd0, 32'h10, 32'hFFFF_FFFF, 32'hF, 32'h0, 32'h0);
        alu_vec("ori",      2'b11, 6'h00, 6'h0D, 5'd0, 32'h0F00, 32'h00F0, 32'h0FF0, 32'h0, 32'h0);
        alu_vec("xori",     2'b11, 6'h00, 6'h0E, 5'd0, 32'hFF, 32'h0F, 32'hF0, 32'h0, 32'h0);
        alu_vec("op_unk",   2'b11, 6'h00, 6'h3F, 5'd0, 32'hFF, 32'h0F, 32'h0, 32'h0, 32'h0);
`ifdef MULTDIV_EN
        alu_vec("mult",     2'b10, 6'h18, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        alu_vec("multu",    2'b10, 6'h19, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h1, 32'hFFFF_FFFE);
        alu_vec("div",      2'b10, 6'h1A, 6'h00, 5'd0, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        alu_vec("divu",     2'b10, 6'h1B, 6'h00, 5'd0, 32'h7, 32'h2, 32'h0, 32'h1, 32'h3);
        alu_vec("div0",     2'b10, 6'h1A, 6'h00, 5'd0, 32'hFFFF_FFF9, 32'h0, 32'h0, 32'h0, 32'h0);
`else
        alu_vec("mult_off", 2'b10, 6'h18, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0, 32'h0);
        alu_vec("multu_off",2'b10, 6'h19, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h0);
        alu_vec("div_off",  2'b10, 6'h1A, 6'h00, 5'd0, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 32'h0);
        alu_vec("divu_off", 2'b10, 6'h1B, 6'h00, 5'd0, 32'h7, 32'h2, 32'h0, 32'h0, 32'h0);
`endif

        // Target priority, clk_enable low so no state changes.
        ctl_vec("pri_j2", 1, 0, 0, 1, 1, 1, 32'h40, 32'h1004, 32'h3000, 32'h2000, 32'h40,   32'h1004, 0);
        ctl_vec("pri_j1", 1, 0, 0, 1, 1, 0, 32'h40, 32'h1004, 32'h3000, 32'h2000, 32'h2000, 32'h1004, 0);
        ctl_vec("pri_cm", 1, 0, 0, 1, 0, 0, 32'h40, 32'h1004, 32'h3000, 32'h2000, 32'h3000, 32'h1004, 0);
        ctl_vec("pri_pc", 1, 0, 0, 0, 0, 0, 32'h40, 32'h1004, 32'h3000, 32'h2000, 32'h1004, 32'h1004, 0);

        // Taken branch, delay slot, hold with clk_enable low, then release.
        ctl_vec("br_issue", 1, 1, 1, 1, 0, 0, 32'h0, 32'h20, 32'h100, 32'h0, 32'h100, 32'h20,  0);
        ctl_vec("br_slot",  1, 0, 0, 0, 0, 0, 32'h0, 32'h24, 32'h100, 32'h0, 32'h24,  32'h100, 1);
        ctl_vec("br_hold",  1, 1, 0, 0, 0, 0, 32'h0, 32'h24, 32'h100, 32'h0, 32'h24,  32'h100, 1);
        ctl_vec("br_done",  1, 0, 0, 0, 0, 0, 32'h0, 32'h28, 32'h100, 32'h0, 32'h28,  32'h28,  0);

        // Async reset with delay pending.
        ctl_vec("pre_rst",  1, 1, 1, 1, 0, 0, 32'h0, 32'h30, 32'h500, 32'h0, 32'h500, 32'h30,  0);
        ctl_vec("rst_pend", 1, 0, 0, 0, 0, 0, 32'h0, 32'h34, 32'h500, 32'h0, 32'h34,  32'h500, 1);
        ctl_vec("rst_async",0, 1, 0, 0, 0, 0, 32'h0, 32'h38, 32'h500, 32'h0, 32'h38,  32'h38,  0);
        ctl_vec("rst_rel",  1, 0, 0, 0, 0, 0, 32'h0, 32'h3C, 32'h500, 32'h0, 32'h3C,  32'h3C,  0);

        // Jump with untaken-branch flag: delay set by jump1.
        ctl_vec("j_issue",  1, 1, 0, 0, 1, 0, 32'h0, 32'h40, 32'h0, 32'h700, 32'h700, 32'h40,  0);
        ctl_vec("j_slot",   1, 0, 0, 0, 0, 0, 32'h0, 32'h44, 32'h0, 32'h700, 32'h44,  32'h700, 1);
        // Untaken branch: delay set, target equals pc_plus4 of the branch.
        ctl_vec("nt_issue", 1, 1, 1, 0, 0, 0, 32'h0, 32'h80, 32'h900, 32'h0, 32'h80,  32'h700, 1);
        ctl_vec("nt_slot",  1, 0, 0, 0, 0, 0, 32'h0, 32'h84, 32'h900, 32'h0, 32'h84,  32'h80,  1);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
